// File: rtl/cdb_result_arbiter.sv
// CDB producer: per-source result FIFOs (ALU, LSB), round-robin grant, registered broadcast.
// Optional CDB_PERF_CNT_EN adds broadcast and per-source stall counters.

module cdb_src_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_WIDTH = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              ready
);
  localparam int FIFO_SIZE = 1 << FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0] FULL_CNT = (FIFO_WIDTH+1)'(FIFO_SIZE);

  logic [DATA_W-1:0]     mem [FIFO_SIZE];
  logic [FIFO_WIDTH-1:0] head, tail;
  logic [FIFO_WIDTH:0]   count;

  assign rdata = mem[head];
  assign empty = (count == '0);
  assign ready = (count != FULL_CNT);

  always_ff @(posedge clk_in) begin
    if (rst_in || clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; pointers alone define occupancy.
  always_ff @(posedge clk_in) begin
    if (push) mem[tail] <= wdata;
  end
endmodule

module cdb_result_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int RoB_WIDTH  = 8,
  parameter int FIFO_WIDTH = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rollback_in,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [RoB_WIDTH-1:0]  alu_RoB_index,
  input  logic [31:0]           alu_value,
  input  logic [ADDR_WIDTH-1:0] alu_next_pc,
  input  logic                  lsb_valid,
  output logic                  lsb_ready,
  input  logic [RoB_WIDTH-1:0]  lsb_RoB_index,
  input  logic [31:0]           lsb_value,
  output logic                  cdb_en,
  output logic [RoB_WIDTH-1:0]  cdb_RoB_index,
  output logic [31:0]           cdb_value,
  output logic [ADDR_WIDTH-1:0] cdb_next_pc,
  output logic                  cdb_src
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_bcast_cnt,
  output logic [31:0]           perf_alu_stall_cnt,
  output logic [31:0]           perf_lsb_stall_cnt
`endif
);
  localparam int NUM_SRC = 2;  // 0 = ALU, 1 = LSB

  typedef struct packed {
    logic [RoB_WIDTH-1:0]  idx;
    logic [31:0]           value;
    logic [ADDR_WIDTH-1:0] next_pc;
  } cdb_ent_t;
  localparam int ENT_W = $bits(cdb_ent_t);

  logic [NUM_SRC-1:0]            src_valid, src_ready, push, pop, empty;
  logic [NUM_SRC-1:0][ENT_W-1:0] wdata, rdata;
  cdb_ent_t                      alu_ent, lsb_ent, sel;
  logic                          active, clr, gnt_alu, gnt_lsb, last_grant;

  assign alu_ent   = '{idx: alu_RoB_index, value: alu_value, next_pc: alu_next_pc};
  assign lsb_ent   = '{idx: lsb_RoB_index, value: lsb_value, next_pc: '0};
  assign wdata[0]  = alu_ent;
  assign wdata[1]  = lsb_ent;
  assign src_valid = {lsb_valid, alu_valid};
  assign alu_ready = src_ready[0];
  assign lsb_ready = src_ready[1];

  assign active = rdy_in & ~rollback_in;
  assign clr    = rdy_in & rollback_in;
  assign push   = src_valid & src_ready & {NUM_SRC{active}};

  // last_grant = 1 means LSB went last, so ALU takes the next tie.
  assign gnt_alu = active & ~empty[0] & (empty[1] | last_grant);
  assign gnt_lsb = active & ~empty[1] & (empty[0] | ~last_grant);
  assign pop     = {gnt_lsb, gnt_alu};
  assign sel     = gnt_lsb ? cdb_ent_t'(rdata[1]) : cdb_ent_t'(rdata[0]);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    cdb_src_fifo #(.DATA_W(ENT_W), .FIFO_WIDTH(FIFO_WIDTH)) u_fifo (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .clr    (clr),
      .push   (push[g]),
      .pop    (pop[g]),
      .wdata  (wdata[g]),
      .rdata  (rdata[g]),
      .empty  (empty[g]),
      .ready  (src_ready[g])
    );
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_en        <= 1'b0;
      cdb_RoB_index <= '0;
      cdb_value     <= '0;
      cdb_next_pc   <= '0;
      cdb_src       <= 1'b0;
      last_grant    <= 1'b1;
    end else if (!rdy_in) begin
      cdb_en <= 1'b0;
    end else if (rollback_in) begin
      cdb_en     <= 1'b0;
      last_grant <= 1'b1;
    end else if (gnt_alu || gnt_lsb) begin
      cdb_en        <= 1'b1;
      cdb_RoB_index <= sel.idx;
      cdb_value     <= sel.value;
      cdb_next_pc   <= gnt_lsb ? '0 : sel.next_pc;
      cdb_src       <= gnt_lsb;
      last_grant    <= gnt_lsb;
    end else begin
      cdb_en <= 1'b0;
    end
  end

`ifdef CDB_PERF_CNT_EN
  // Counted at the edge that launches the pulse, so the value tracks visible pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_bcast_cnt     <= '0;
      perf_alu_stall_cnt <= '0;
      perf_lsb_stall_cnt <= '0;
    end else begin
      if (gnt_alu || gnt_lsb)                perf_bcast_cnt     <= perf_bcast_cnt + 1'b1;
      if (rdy_in && alu_valid && !alu_ready) perf_alu_stall_cnt <= perf_alu_stall_cnt + 1'b1;
      if (rdy_in && lsb_valid && !lsb_ready) perf_lsb_stall_cnt <= perf_lsb_stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cdb_result_arbiter.sv
// Directed bench for cdb_result_arbiter: inputs change and outputs are checked on the falling edge.

module tb_cdb_result_arbiter;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rollback_in;
  logic        alu_valid, alu_ready, lsb_valid, lsb_ready;
  logic [7:0]  alu_RoB_index, lsb_RoB_index, cdb_RoB_index;
  logic [31:0] alu_value, lsb_value, cdb_value, alu_next_pc, cdb_next_pc;
  logic        cdb_en, cdb_src;
`ifdef CDB_PERF_CNT_EN
  logic [31:0] perf_bcast_cnt, perf_alu_stall_cnt, perf_lsb_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  cdb_result_arbiter dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .rollback_in   (rollback_in),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_RoB_index (alu_RoB_index),
    .alu_value     (alu_value),
    .alu_next_pc   (alu_next_pc),
    .lsb_valid     (lsb_valid),
    .lsb_ready     (lsb_ready),
    .lsb_RoB_index (lsb_RoB_index),
    .lsb_value     (lsb_value),
    .cdb_en        (cdb_en),
    .cdb_RoB_index (cdb_RoB_index),
    .cdb_value     (cdb_value),
    .cdb_next_pc   (cdb_next_pc),
    .cdb_src       (cdb_src)
`ifdef CDB_PERF_CNT_EN
    ,
    .perf_bcast_cnt     (perf_bcast_cnt),
    .perf_alu_stall_cnt (perf_alu_stall_cnt),
    .perf_lsb_stall_cnt (perf_lsb_stall_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic v, input logic [7:0] idx);
    alu_valid     = v;
    alu_RoB_index = idx;
    alu_value     = 32'hA000_0000 | 32'(idx);
    alu_next_pc   = 32'h0000_4000 | 32'(idx);
  endtask

  task automatic lsb(input logic v, input logic [7:0] idx);
    lsb_valid     = v;
    lsb_RoB_index = idx;
    lsb_value     = 32'hC000_0000 | 32'(idx);
  endtask

  task automatic none(input string tag);
    chk({tag, ".en"}, 64'(cdb_en), 64'd0);
  endtask

  // Expected broadcast: payload follows the tagging scheme of alu()/lsb().
  task automatic bc(input string tag, input logic [7:0] idx, input logic src);
    chk({tag, ".en"},  64'(cdb_en), 64'd1);
    chk({tag, ".idx"}, 64'(cdb_RoB_index), 64'(idx));
    chk({tag, ".src"}, 64'(cdb_src), 64'(src));
    chk({tag, ".val"}, 64'(cdb_value), 64'((src ? 32'hC000_0000 : 32'hA000_0000) | 32'(idx)));
    chk({tag, ".npc"}, 64'(cdb_next_pc), 64'(src ? 32'h0 : (32'h0000_4000 | 32'(idx))));
  endtask

  task automatic do_reset();
    alu(1'b0, 8'h0);
    lsb(1'b0, 8'h0);
    rdy_in = 1'b1;
    rollback_in = 1'b0;
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    // 1: reset state, single ALU result latency
    do_reset();
    chk("rst.en", 64'(cdb_en), 64'd0);
    chk("rst.idx", 64'(cdb_RoB_index), 64'd0);
    chk("rst.val", 64'(cdb_value), 64'd0);
    chk("rst.npc", 64'(cdb_next_pc), 64'd0);
    chk("rst.src", 64'(cdb_src), 64'd0);
    chk("rst.alu_rdy", 64'(alu_ready), 64'd1);
    chk("rst.lsb_rdy", 64'(lsb_ready), 64'd1);
    alu_valid = 1'b1; alu_RoB_index = 8'd3; alu_value = 32'h11; alu_next_pc = 32'h100;
    tick(); none("t1.e1");
    alu(1'b0, 8'h0);
    tick();
    chk("t1.en", 64'(cdb_en), 64'd1);
    chk("t1.idx", 64'(cdb_RoB_index), 64'd3);
    chk("t1.val", 64'(cdb_value), 64'h11);
    chk("t1.npc", 64'(cdb_next_pc), 64'h100);
    chk("t1.src", 64'(cdb_src), 64'd0);
    tick(); none("t1.e3");
    chk("t1.hold_idx", 64'(cdb_RoB_index), 64'd3);

    // 2: simultaneous pushes alternate, ALU first
    do_reset();
    alu(1'b1, 8'd1); lsb(1'b1, 8'd2); tick(); none("t2.e1");
    alu(1'b1, 8'd4); lsb(1'b1, 8'd5); tick(); bc("t2.b0", 8'd1, 1'b0);
    alu(1'b0, 8'd0); lsb(1'b0, 8'd0); tick(); bc("t2.b1", 8'd2, 1'b1);
    tick(); bc("t2.b2", 8'd4, 1'b0);
    tick(); bc("t2.b3", 8'd5, 1'b1);
    tick(); none("t2.end");

    // 3: LSB FIFO fills while held valid; held entry accepted after a pop
    do_reset();
    alu(1'b1, 8'h10); lsb(1'b1, 8'h20); tick(); none("t3.e1");
    alu(1'b1, 8'h11); lsb(1'b1, 8'h21); tick(); bc("t3.e2", 8'h10, 1'b0);
    alu(1'b1, 8'h12); lsb(1'b1, 8'h22); tick(); bc("t3.e3", 8'h20, 1'b1);
    alu(1'b1, 8'h13); lsb(1'b1, 8'h23); tick(); bc("t3.e4", 8'h11, 1'b0);
    alu(1'b0, 8'h00); lsb(1'b1, 8'h24); tick(); bc("t3.e5", 8'h21, 1'b1);
    chk("t3.rdy5", 64'(lsb_ready), 64'd1);
    lsb(1'b1, 8'h25); tick(); bc("t3.e6", 8'h12, 1'b0);
    chk("t3.full6", 64'(lsb_ready), 64'd0);
    lsb(1'b1, 8'h26); tick(); bc("t3.e7", 8'h22, 1'b1);
    chk("t3.rdy7", 64'(lsb_ready), 64'd1);
    tick(); bc("t3.e8", 8'h13, 1'b0);
    chk("t3.full8", 64'(lsb_ready), 64'd0);
    lsb(1'b0, 8'h00); tick(); bc("t3.e9", 8'h23, 1'b1);
    chk("t3.rdy9", 64'(lsb_ready), 64'd1);
    tick(); bc("t3.e10", 8'h24, 1'b1);
    tick(); bc("t3.e11", 8'h25, 1'b1);
    tick(); bc("t3.e12", 8'h26, 1'b1);
    tick(); none("t3.e13");
`ifdef CDB_PERF_CNT_EN
    chk("t3.lsb_stall", 64'(perf_lsb_stall_cnt), 64'd1);
    chk("t3.alu_stall", 64'(perf_alu_stall_cnt), 64'd0);
`endif

    // 4: rollback flushes queued entries and re-arms the ALU tie-break
    do_reset();
    alu(1'b1, 8'h50); lsb(1'b1, 8'h60); tick(); none("t4.e1");
    alu(1'b1, 8'h51); lsb(1'b1, 8'h61); tick(); bc("t4.e2", 8'h50, 1'b0);
    alu(1'b1, 8'h52); lsb(1'b0, 8'h00); tick(); bc("t4.e3", 8'h60, 1'b1);
    alu(1'b0, 8'h00); tick(); bc("t4.e4", 8'h51, 1'b0);
    rollback_in = 1'b1; alu(1'b1, 8'hEE); lsb(1'b1, 8'hEF);
    tick(); none("t4.rb");
    rollback_in = 1'b0; alu(1'b0, 8'h00); lsb(1'b0, 8'h00);
    chk("t4.alu_rdy", 64'(alu_ready), 64'd1);
    chk("t4.lsb_rdy", 64'(lsb_ready), 64'd1);
    tick(); none("t4.q1");
    tick(); none("t4.q2");
    alu(1'b1, 8'h77); lsb(1'b1, 8'h66); tick(); none("t4.e8");
    alu(1'b0, 8'h00); lsb(1'b0, 8'h00); tick(); bc("t4.e9", 8'h77, 1'b0);
    tick(); bc("t4.e10", 8'h66, 1'b1);
    tick(); none("t4.end");

    // 5: freeze holds everything, rollback and pushes ignored while frozen
    do_reset();
    alu(1'b1, 8'h30); lsb(1'b1, 8'h40); tick(); none("t5.e1");
    rdy_in = 1'b0; rollback_in = 1'b1; alu(1'b1, 8'h99); lsb(1'b0, 8'h00);
    tick(); none("t5.f1");
    rollback_in = 1'b0;
    tick(); none("t5.f2");
    tick(); none("t5.f3");
    chk("t5.alu_rdy", 64'(alu_ready), 64'd1);
    chk("t5.lsb_rdy", 64'(lsb_ready), 64'd1);
    rdy_in = 1'b1; alu(1'b0, 8'h00);
    tick(); bc("t5.u1", 8'h30, 1'b0);
    tick(); bc("t5.u2", 8'h40, 1'b1);
    tick(); none("t5.u3");
    tick(); none("t5.u4");

    // 6: nine pushes wrap the ALU pointers
    do_reset();
    for (int i = 0; i < 9; i++) begin
      alu(1'b1, 8'(i));
      tick();
      if (i == 0) none("t6.first");
      else bc($sformatf("t6.b%0d", i - 1), 8'(i - 1), 1'b0);
    end
    alu(1'b0, 8'h00);
    tick(); bc("t6.b8", 8'd8, 1'b0);
    tick(); none("t6.end");
`ifdef CDB_PERF_CNT_EN
    chk("t6.bcast", 64'(perf_bcast_cnt), 64'd9);
`endif

    // reset in the middle of a burst drops everything
    alu(1'b1, 8'h0A); lsb(1'b1, 8'h0B); tick();
    alu(1'b0, 8'h00); lsb(1'b0, 8'h00); rst_in = 1'b1;
    tick(); none("t7.rst");
    rst_in = 1'b0;
    tick(); none("t7.after1");
    tick(); none("t7.after2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
